// File: rtl/single_port_ram_param.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable
// read-during-write behaviour, registered read + valid, and optional clear sweep.
module single_port_ram_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int BYTE_W         = 8,
  parameter int RW_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int NB    = DATA_WIDTH / BYTE_W,
  localparam int DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  write_enable,
  input  logic [NB-1:0]         byte_en,
  input  logic [ADDR_WIDTH-1:0] ram_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word_d;
  logic                  clr_ok;
  logic                  wr_ok;

  assign rd_word = mem[ram_address];

  // Merge enabled lanes of data_in over the current word; a zero mask yields the old word.
  always_comb begin
    wr_word_d = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) wr_word_d[i*BYTE_W +: BYTE_W] = data_in[i*BYTE_W +: BYTE_W];
    end
  end

  // Reset wins over both the sweep and any user request at the same edge.
  assign clr_ok = (state_q == CLEAR) && !rst;
  assign wr_ok  = (state_q == IDLE) && !rst && en && write_enable;

  always_ff @(posedge clk) begin
    if (clr_ok) begin
      mem[clr_ptr_q] <= INIT_VALUE;
    end else if (wr_ok) begin
      mem[ram_address] <= wr_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      busy_q     <= (CLEAR_ON_RESET != 0);
      clr_ptr_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
          if (clr_ptr_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (en) begin
            if (!write_enable) begin
              data_out_q <= rd_word;
              rd_valid_q <= 1'b1;
            end else if (RW_MODE == 0) begin
              data_out_q <= rd_word;
              rd_valid_q <= 1'b1;
            end else if (RW_MODE == 1) begin
              data_out_q <= wr_word_d;
              rd_valid_q <= 1'b1;
            end
            // No-change mode: a write leaves data_out and rd_valid untouched/low.
          end
        end
      endcase
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_single_port_ram_param.sv
// Directed bench: three RAM instances (read-first, write-first, no-change) share
// one stimulus stream; a vector table covers steady-state accesses.
module tb_single_port_ram_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        write_enable;
  logic [3:0]  byte_en;
  logic [5:0]  ram_address;
  logic [31:0] data_in;
  logic [31:0] dout [3];
  logic        vld  [3];
  logic        bsy  [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  single_port_ram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_W(8), .RW_MODE(0),
                          .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)) u_m0 (
    .clk(clk), .rst(rst), .en(en), .write_enable(write_enable), .byte_en(byte_en),
    .ram_address(ram_address), .data_in(data_in),
    .data_out(dout[0]), .rd_valid(vld[0]), .busy(bsy[0]));

  single_port_ram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_W(8), .RW_MODE(1),
                          .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)) u_m1 (
    .clk(clk), .rst(rst), .en(en), .write_enable(write_enable), .byte_en(byte_en),
    .ram_address(ram_address), .data_in(data_in),
    .data_out(dout[1]), .rd_valid(vld[1]), .busy(bsy[1]));

  single_port_ram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_W(8), .RW_MODE(2),
                          .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .write_enable(write_enable), .byte_en(byte_en),
    .ram_address(ram_address), .data_in(data_in),
    .data_out(dout[2]), .rd_valid(vld[2]), .busy(bsy[2]));

  typedef struct {
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_do [3];
    logic        exp_vld [3];
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (mode %0d): got 0x%08h, expected 0x%08h", name, m, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic w, input logic [3:0] b,
                      input logic [5:0] a, input logic [31:0] d);
    rst = r; en = e; write_enable = w; byte_en = b; ram_address = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Counts samples with busy high, starting with the sample right after the reset edge.
  // A write to addr 3 is attempted on sweep step wr_at to confirm requests are ignored.
  task automatic count_busy(input string name, input int wr_at);
    int n [3];
    n = '{0, 0, 0};
    for (int k = 0; k < 200; k++) begin
      for (int m = 0; m < 3; m++) if (bsy[m]) n[m]++;
      if (!bsy[0] && !bsy[1] && !bsy[2]) break;
      if (k == wr_at) step(1'b0, 1'b1, 1'b1, 4'hF, 6'd3, 32'h0000_0055);
      else            step(1'b0, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
      if (k == wr_at)
        for (int m = 0; m < 3; m++) check({name, " vld while busy"}, m, 32'(vld[m]), 32'd0);
    end
    for (int m = 0; m < 3; m++) check(name, m, n[m], 32'd64);
  endtask

  function automatic vec_t mk(input logic e, input logic w, input logic [3:0] b, input logic [5:0] a,
                              input logic [31:0] d, input logic [31:0] d0, input logic v0,
                              input logic [31:0] d1, input logic v1, input logic [31:0] d2,
                              input logic v2);
    vec_t v;
    v.en = e; v.we = w; v.be = b; v.addr = a; v.din = d;
    v.exp_do[0] = d0; v.exp_vld[0] = v0;
    v.exp_do[1] = d1; v.exp_vld[1] = v1;
    v.exp_do[2] = d2; v.exp_vld[2] = v2;
    return v;
  endfunction

  initial begin
    // Read 0x3F after the sweep, then basic writes/reads.
    tbl.push_back(mk(1, 0, 4'h0, 6'h3F, 32'h0,        32'h0, 1, 32'h0, 1, 32'h0, 1));
    tbl.push_back(mk(1, 1, 4'hF, 6'd0,  32'h10,       32'h0, 1, 32'h10, 1, 32'h0, 0));
    tbl.push_back(mk(1, 1, 4'hF, 6'd2,  32'h11,       32'h0, 1, 32'h11, 1, 32'h0, 0));
    tbl.push_back(mk(1, 1, 4'hF, 6'd7,  32'hAF,       32'h0, 1, 32'hAF, 1, 32'h0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 6'd0,  32'h0,        32'h10, 1, 32'h10, 1, 32'h10, 1));
    tbl.push_back(mk(1, 0, 4'h0, 6'd2,  32'h0,        32'h11, 1, 32'h11, 1, 32'h11, 1));
    tbl.push_back(mk(1, 0, 4'h0, 6'd7,  32'h0,        32'hAF, 1, 32'hAF, 1, 32'hAF, 1));
    // Byte lanes.
    tbl.push_back(mk(1, 1, 4'hF, 6'd5, 32'hDEADBEEF, 32'h0, 1, 32'hDEADBEEF, 1, 32'hAF, 0));
    tbl.push_back(mk(1, 1, 4'b0101, 6'd5, 32'h11223344, 32'hDEADBEEF, 1, 32'hDE22BE44, 1, 32'hAF, 0));
    tbl.push_back(mk(1, 0, 4'h0, 6'd5, 32'h0,        32'hDE22BE44, 1, 32'hDE22BE44, 1, 32'hDE22BE44, 1));
    tbl.push_back(mk(1, 1, 4'h0, 6'd5, 32'h99999999, 32'hDE22BE44, 1, 32'hDE22BE44, 1, 32'hDE22BE44, 0));
    tbl.push_back(mk(1, 0, 4'h0, 6'd5, 32'h0,        32'hDE22BE44, 1, 32'hDE22BE44, 1, 32'hDE22BE44, 1));
    // Read-during-write.
    tbl.push_back(mk(1, 1, 4'hF, 6'd5, 32'hDEADBEEF, 32'hDE22BE44, 1, 32'hDEADBEEF, 1, 32'hDE22BE44, 0));
    tbl.push_back(mk(1, 1, 4'hF, 6'd5, 32'hCAFEF00D, 32'hDEADBEEF, 1, 32'hCAFEF00D, 1, 32'hDE22BE44, 0));
    tbl.push_back(mk(1, 0, 4'h0, 6'd5, 32'h0,        32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1));
    // Hold with en=0, including a disabled write that must not land.
    tbl.push_back(mk(1, 0, 4'h0, 6'd2, 32'h0,        32'h11, 1, 32'h11, 1, 32'h11, 1));
    tbl.push_back(mk(0, 0, 4'h0, 6'd7, 32'h0,        32'h11, 0, 32'h11, 0, 32'h11, 0));
    tbl.push_back(mk(0, 1, 4'hF, 6'd2, 32'hFFFFFFFF, 32'h11, 0, 32'h11, 0, 32'h11, 0));
    tbl.push_back(mk(0, 0, 4'h0, 6'd5, 32'h0,        32'h11, 0, 32'h11, 0, 32'h11, 0));
    tbl.push_back(mk(0, 1, 4'h3, 6'd0, 32'h12345678, 32'h11, 0, 32'h11, 0, 32'h11, 0));
    tbl.push_back(mk(0, 0, 4'h0, 6'd2, 32'h0,        32'h11, 0, 32'h11, 0, 32'h11, 0));
    tbl.push_back(mk(1, 0, 4'h0, 6'd2, 32'h0,        32'h11, 1, 32'h11, 1, 32'h11, 1));
    tbl.push_back(mk(1, 0, 4'h0, 6'd0, 32'h0,        32'h10, 1, 32'h10, 1, 32'h10, 1));

    // Reset state and first clear sweep.
    step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    for (int m = 0; m < 3; m++) begin
      check("reset data_out", m, dout[m], 32'h0);
      check("reset rd_valid", m, 32'(vld[m]), 32'd0);
      check("reset busy", m, 32'(bsy[m]), 32'd1);
    end
    count_busy("busy length", -1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].en, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].din);
      for (int m = 0; m < 3; m++) begin
        check($sformatf("vec%0d data_out", i), m, dout[m], tbl[i].exp_do[m]);
        check($sformatf("vec%0d rd_valid", i), m, 32'(vld[m]), 32'(tbl[i].exp_vld[m]));
      end
    end

    // Reset with a simultaneous read: request dropped, outputs cleared.
    step(1'b1, 1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
    for (int m = 0; m < 3; m++) begin
      check("rst+read data_out", m, dout[m], 32'h0);
      check("rst+read rd_valid", m, 32'(vld[m]), 32'd0);
    end

    // Let 20 sweep cycles run, then reset mid-sweep; sweep restarts with full busy period.
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    count_busy("busy after mid-sweep reset", 30);

    step(1'b0, 1'b1, 1'b0, 4'h0, 6'd3, 32'h0);
    for (int m = 0; m < 3; m++) begin
      check("addr3 after locked-out write", m, dout[m], 32'h0);
      check("addr3 rd_valid", m, 32'(vld[m]), 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0, 6'd2, 32'h0);
    for (int m = 0; m < 3; m++) check("addr2 cleared", m, dout[m], 32'h0);
    step(1'b0, 1'b1, 1'b1, 4'hF, 6'd3, 32'hA5A5_0001);
    step(1'b0, 1'b1, 1'b0, 4'h0, 6'd3, 32'h0);
    for (int m = 0; m < 3; m++) check("addr3 write after sweep", m, dout[m], 32'hA5A5_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
